// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 bit-select mux; streams the selected bit
// to one consumer over valid/ready, holding each grant for at most HOLD_MAX beats.
module mux16_rr_sched #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [15:0]      req_i,
    output logic [3:0]       sel_o,
    input  logic             mux_d_i,
    output logic [15:0]      gnt_o,
    output logic             valid_o,
    output logic             data_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] gnt_cnt_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] beat_cnt_o
);

    // Handshake: a beat transfers in any cycle where valid_o & ready_i is high
    // at the rising edge; valid_o never depends on ready_i, and data_o is
    // stable whenever valid_o is high.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       last;
    logic [3:0]       winner;
    logic             found;
    logic [CNT_W-1:0] beat_cnt;
    logic             owner_req;
    logic             xfer;
    logic             last_beat;

    // Scan last+1 .. last+16 (mod 16); the final step wraps back to last itself.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (!found && req_i[last + 4'(i)]) begin
                winner = last + 4'(i);
                found  = 1'b1;
            end
        end
    end

    assign owner_req  = req_i[sel_o];
    assign valid_o    = (state == ST_GRANT) && owner_req;
    assign data_o     = valid_o & mux_d_i;
    assign xfer       = valid_o & ready_i;
    assign last_beat  = (beat_cnt == BEAT_LAST);
    assign state_o    = state;
    assign beat_cnt_o = beat_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (en_i && found) state_nxt = ST_GRANT;
            ST_GRANT:   if (!owner_req || (xfer && last_beat)) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            sel_o     <= '0;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            gnt_cnt_o <= '0;
            last      <= 4'd15;
            beat_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_GRANT) begin
                        sel_o     <= winner;
                        gnt_o     <= 16'd1 << winner;
                        beat_cnt  <= '0;
                        gnt_cnt_o <= gnt_cnt_o + CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    if (xfer) beat_cnt <= beat_cnt + CNT_W'(1);
                    if (state_nxt == ST_RELEASE) gnt_o <= '0;
                end
                ST_RELEASE: last <= sel_o;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: a reset/arbitration vector table plus
// hand-written multi-cycle sequences; two instances (HOLD_MAX 8 and 2).
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [15:0] req = '0;
    logic        ready = 1'b1;
    logic [15:0] pat = 16'hA5C3;

    logic [3:0]  sel_a, sel_b;
    logic        mux_d_a, mux_d_b;
    logic [15:0] gnt_a, gnt_b;
    logic        valid_a, valid_b, data_a, data_b, busy_a, busy_b;
    logic [7:0]  gnt_cnt_a, gnt_cnt_b, beat_a, beat_b;
    logic [1:0]  state_a, state_b;

    int checks = 0;
    int failures = 0;

    assign mux_d_a = pat[sel_a];
    assign mux_d_b = pat[sel_b];

    always #5 clk = ~clk;

    mux16_rr_sched #(.HOLD_MAX(8), .CNT_W(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .sel_o(sel_a),
        .mux_d_i(mux_d_a), .gnt_o(gnt_a), .valid_o(valid_a), .data_o(data_a),
        .ready_i(ready), .busy_o(busy_a), .gnt_cnt_o(gnt_cnt_a),
        .state_o(state_a), .beat_cnt_o(beat_a)
    );

    mux16_rr_sched #(.HOLD_MAX(2), .CNT_W(8)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req), .sel_o(sel_b),
        .mux_d_i(mux_d_b), .gnt_o(gnt_b), .valid_o(valid_b), .data_o(data_b),
        .ready_i(ready), .busy_o(busy_b), .gnt_cnt_o(gnt_cnt_b),
        .state_o(state_b), .beat_cnt_o(beat_b)
    );

    typedef struct {
        logic        en;
        logic [15:0] req;
        logic [15:0] exp_gnt;
        logic [3:0]  exp_sel;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        en    = 1'b1;
        ready = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int beats;
        int cyc;
        int n;
        logic [15:0] prev;
        logic [15:0] got [3];

        vecs[0] = '{1'b1, 16'h0010, 16'h0010, 4'd4,  1'b1};
        vecs[1] = '{1'b1, 16'h0201, 16'h0001, 4'd0,  1'b1};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, 4'd15, 1'b1};
        vecs[3] = '{1'b1, 16'h00F0, 16'h0010, 4'd4,  1'b1};
        vecs[4] = '{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b0};
        vecs[5] = '{1'b0, 16'h0100, 16'h0000, 4'd0,  1'b0};
        vecs[6] = '{1'b1, 16'h0100, 16'h0100, 4'd8,  1'b1};
        vecs[7] = '{1'b1, 16'hC000, 16'h4000, 4'd14, 1'b1};

        // Reset values while reset is held with a request present.
        rst_n = 1'b0;
        req   = 16'h0010;
        step();
        check("rst_gnt", 32'(gnt_a), 32'h0);
        check("rst_sel", 32'(sel_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_data", 32'(data_a), 32'h0);
        check("rst_gnt_cnt", 32'(gnt_cnt_a), 32'h0);
        check("rst_beat", 32'(beat_a), 32'h0);

        // First arbitration after reset starts at index 0.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            en  = vecs[v].en;
            req = vecs[v].req;
            step();
            check($sformatf("vec%0d_gnt", v), 32'(gnt_a), 32'(vecs[v].exp_gnt));
            check($sformatf("vec%0d_sel", v), 32'(sel_a), 32'(vecs[v].exp_sel));
            check($sformatf("vec%0d_busy", v), 32'(busy_a), 32'(vecs[v].exp_busy));
        end

        // Single request: 8 beats, release, regrant two cycles later.
        do_reset();
        req = 16'h0010;
        step();
        check("single_sel", 32'(sel_a), 32'd4);
        check("single_gnt", 32'(gnt_a), 32'h0010);
        check("single_gnt_cnt1", 32'(gnt_cnt_a), 32'd1);
        beats = 0;
        cyc = 0;
        while (gnt_a != 0 && cyc < 50) begin
            if (valid_a && ready) begin
                beats++;
                check("single_data", 32'(data_a), 32'(pat[4]));
            end
            pat = ~pat;
            step();
            cyc++;
        end
        check("single_beats", beats, 8);
        check("single_release_state", 32'(state_a), 32'd2);
        check("single_release_busy", 32'(busy_a), 32'd1);
        check("single_release_valid", 32'(valid_a), 32'd0);
        step();
        check("single_idle_gnt", 32'(gnt_a), 32'h0);
        check("single_idle_busy", 32'(busy_a), 32'd0);
        step();
        check("single_regrant", 32'(gnt_a), 32'h0010);
        check("single_gnt_cnt2", 32'(gnt_cnt_a), 32'd2);

        // All requesting on the HOLD_MAX=2 instance.
        do_reset();
        req = 16'hFFFF;
        step();
        for (int k = 0; k < 17; k++) begin
            check($sformatf("all_gnt%0d", k), 32'(gnt_b), 32'(16'd1 << (k % 16)));
            beats = 0;
            for (int j = 0; j < 4; j++) begin
                if (valid_b && ready) beats++;
                step();
            end
            check($sformatf("all_beats%0d", k), beats, 2);
        end

        // Fairness after wrap: last owner 14, then 0x8003 -> 15, 0, 1.
        do_reset();
        req = 16'h4000;
        step();
        check("fair_gnt14", 32'(gnt_a), 32'h4000);
        req = 16'h8003;
        step();
        got[0] = '0; got[1] = '0; got[2] = '0;
        n = 0;
        cyc = 0;
        prev = gnt_a;
        while (n < 3 && cyc < 100) begin
            if (prev == 0 && gnt_a != 0) begin
                got[n] = gnt_a;
                n++;
            end
            prev = gnt_a;
            step();
            cyc++;
        end
        check("fair_count", n, 3);
        check("fair_first", 32'(got[0]), 32'h8000);
        check("fair_second", 32'(got[1]), 32'h0001);
        check("fair_third", 32'(got[2]), 32'h0002);

        // Stall then early release.
        do_reset();
        req   = 16'h0008;
        ready = 1'b0;
        step();
        check("stall_gnt", 32'(gnt_a), 32'h0008);
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 32'(valid_a), 32'd1);
            step();
        end
        check("stall_beat", 32'(beat_a), 32'd0);
        check("stall_still_gnt", 32'(gnt_a), 32'h0008);
        ready = 1'b1;
        step();
        step();
        check("early_beat2", 32'(beat_a), 32'd2);
        req = 16'h0000;
        #1;
        check("early_valid_drop", 32'(valid_a), 32'd0);
        check("early_state_grant", 32'(state_a), 32'd1);
        step();
        check("early_release_state", 32'(state_a), 32'd2);
        check("early_release_gnt", 32'(gnt_a), 32'h0);
        check("early_release_beat", 32'(beat_a), 32'd2);

        // Enable gating.
        do_reset();
        en  = 1'b0;
        req = 16'h0100;
        for (int s = 0; s < 3; s++) step();
        check("en_idle_gnt", 32'(gnt_a), 32'h0);
        check("en_idle_state", 32'(state_a), 32'd0);
        check("en_idle_cnt", 32'(gnt_cnt_a), 32'd0);
        en = 1'b1;
        step();
        check("en_gnt", 32'(gnt_a), 32'h0100);
        en = 1'b0;
        beats = 0;
        cyc = 0;
        while (gnt_a != 0 && cyc < 50) begin
            if (valid_a && ready) beats++;
            step();
            cyc++;
        end
        check("en_finish_beats", beats, 8);
        step();
        step();
        check("en_blocked_gnt", 32'(gnt_a), 32'h0);
        check("en_blocked_state", 32'(state_a), 32'd0);
        check("en_blocked_cnt", 32'(gnt_cnt_a), 32'd1);

        // Asynchronous reset mid-grant.
        do_reset();
        req = 16'h0200;
        step();
        check("arst_gnt9", 32'(gnt_a), 32'h0200);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt_a), 32'h0);
        check("arst_valid", 32'(valid_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        req = 16'h0201;
        step();
        rst_n = 1'b1;
        step();
        check("arst_regrant_gnt", 32'(gnt_a), 32'h0001);
        check("arst_regrant_sel", 32'(sel_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
